// File: rtl/serial_rx_ctrl.sv
// -----------------------------------------------------------------------------
// serial_rx_ctrl
//   Control block for an 8N1 asynchronous receiver datapath.
//   - Generates the 8x-oversample baud tick from a programmable divisor
//     (tick period = divisor + 1 clocks).
//   - Sequences receiver enable/disable (OFF -> ARM -> RUN -> STOP) so the
//     receiver only starts or stops on an idle line.
//   - Buffers received bytes in a first-word-fall-through FIFO and raises
//     overrun, fill-threshold and packet-gap timeout interrupt conditions.
//
// Optional feature macro: SERIAL_RX_CTRL_STATS_EN
//   When defined, adds input stat_clr and outputs stat_bytes / stat_drops
//   (saturating counts of accepted bytes and of bytes dropped on overrun).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_div, cfg_div_we new baud divisor and its load strobe
//   rx_en               receive enable request (level)
//   cfg_thresh          FIFO fill threshold for the threshold interrupt (0 = off)
//   irq_mask            enables for {timeout, thresh, overrun}
//   ovr_clr             clears the sticky overrun flag
//   baud8tick           one-clock tick to the receiver
//   rxd_data/_ready     received byte and its valid pulse
//   rxd_endofpacket     gap-detected pulse from the receiver
//   rxd_idle            receiver line idle
//   rd_pop              consume the FIFO head
//   rd_data, rd_valid   FIFO head byte, FIFO non-empty
//   fifo_count          entries held, 0..2**AW
//   overrun             sticky byte-dropped flag
//   rx_active           controller is in RUN
//   irq                 registered OR of the masked interrupt sources
// -----------------------------------------------------------------------------
module serial_rx_ctrl #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd26,
  parameter int               AW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_div_we,
  input  logic             rx_en,
  input  logic [AW:0]      cfg_thresh,
  input  logic [2:0]       irq_mask,
  input  logic             ovr_clr,
  output logic             baud8tick,
  input  logic [7:0]       rxd_data,
  input  logic             rxd_data_ready,
  input  logic             rxd_endofpacket,
  input  logic             rxd_idle,
  input  logic             rd_pop,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [AW:0]      fifo_count,
  output logic             overrun,
  output logic             rx_active,
  output logic             irq
`ifdef SERIAL_RX_CTRL_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_bytes,
  output logic [15:0]      stat_drops
`endif
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] baud_cnt;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             timeout;

  logic accepting;
  logic push_req;
  logic pop_ok;
  logic full;
  logic push_ok;
  logic drop;
  logic go_off;
  logic thresh_hit;

  // Tick is a decode of the running counter; it is forced low while OFF.
  assign baud8tick = (state != ST_OFF) && (baud_cnt == {DIV_W{1'b0}});

  assign accepting  = (state == ST_RUN) || (state == ST_STOP);
  assign push_req   = rxd_data_ready && accepting;
  assign pop_ok     = rd_pop && (fifo_count != {(AW+1){1'b0}});
  assign full       = (fifo_count == FULL_CNT);
  // A full FIFO still takes a byte when the head is popped in the same cycle.
  assign push_ok    = push_req && (!full || pop_ok);
  assign drop       = push_req && full && !pop_ok;
  assign thresh_hit = (cfg_thresh != {(AW+1){1'b0}}) && (fifo_count >= cfg_thresh);
  // Every FSM transition that lands in OFF from another state.
  assign go_off     = ((state == ST_ARM)  && !rx_en) ||
                      ((state == ST_RUN)  && !rx_en && rxd_idle) ||
                      ((state == ST_STOP) && rxd_idle);

  assign rd_valid = (fifo_count != {(AW+1){1'b0}});
  assign rd_data  = mem[rd_ptr];

  // Divisor register: a new value only takes effect at the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DIV_RST;
    end else if (cfg_div_we) begin
      divisor <= cfg_div;
    end else begin
      divisor <= divisor;
    end
  end

  // Baud down-counter: parked at the divisor while OFF, reloads on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= {DIV_W{1'b0}};
    end else if (state == ST_OFF) begin
      baud_cnt <= divisor;
    end else if (baud_cnt == {DIV_W{1'b0}}) begin
      baud_cnt <= divisor;
    end else begin
      baud_cnt <= baud_cnt - DIV_W'(1);
    end
  end

  // Enable sequencer with registered rx_active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      rx_active <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          rx_active <= 1'b0;
          if (rx_en) begin
            state <= ST_ARM;
          end else begin
            state <= ST_OFF;
          end
        end
        ST_ARM: begin
          if (!rx_en) begin
            state     <= ST_OFF;
            rx_active <= 1'b0;
          end else if (baud8tick && rxd_idle) begin
            state     <= ST_RUN;
            rx_active <= 1'b1;
          end else begin
            state     <= ST_ARM;
            rx_active <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!rx_en) begin
            state     <= rxd_idle ? ST_OFF : ST_STOP;
            rx_active <= 1'b0;
          end else begin
            state     <= ST_RUN;
            rx_active <= 1'b1;
          end
        end
        ST_STOP: begin
          // Line going idle wins: the in-flight frame is finished.
          if (rxd_idle) begin
            state     <= ST_OFF;
            rx_active <= 1'b0;
          end else if (rx_en) begin
            state     <= ST_RUN;
            rx_active <= 1'b1;
          end else begin
            state     <= ST_STOP;
            rx_active <= 1'b0;
          end
        end
        default: begin
          state     <= ST_OFF;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      fifo_count <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rxd_data;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

  // Packet-gap timeout: a gap seen in the same cycle as a pop still flags,
  // so the interrupt does not drop while bytes remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (go_off) begin
      timeout <= 1'b0;
    end else if (rxd_endofpacket && accepting && (fifo_count != {(AW+1){1'b0}})) begin
      timeout <= 1'b1;
    end else if (pop_ok) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout;
    end
  end

  // Interrupt output, one clock behind its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (irq_mask[2] & timeout) | (irq_mask[1] & thresh_hit) | (irq_mask[0] & overrun);
    end
  end

`ifdef SERIAL_RX_CTRL_STATS_EN
  // Saturating traffic statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bytes <= 16'd0;
      stat_drops <= 16'd0;
    end else if (stat_clr) begin
      stat_bytes <= 16'd0;
      stat_drops <= 16'd0;
    end else begin
      if (push_ok && (stat_bytes != 16'hFFFF)) begin
        stat_bytes <= stat_bytes + 16'd1;
      end else begin
        stat_bytes <= stat_bytes;
      end
      if (drop && (stat_drops != 16'hFFFF)) begin
        stat_drops <= stat_drops + 16'd1;
      end else begin
        stat_drops <= stat_drops;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_ctrl
//   Self-checking bench for serial_rx_ctrl (default build). A behavioural
//   model (byte queue, mode, tick phase) is stepped alongside the DUT and all
//   outputs are compared every cycle; directed scenarios add hand-derived
//   checks, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_serial_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int M_OFF = 0, M_ARM = 1, M_RUN = 2, M_STOP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic        cfg_div_we = 1'b0;
  logic        rx_en = 1'b0;
  logic [4:0]  cfg_thresh = 5'd0;
  logic [2:0]  irq_mask = 3'd0;
  logic        ovr_clr = 1'b0;
  logic        baud8tick;
  logic [7:0]  rxd_data = 8'd0;
  logic        rxd_data_ready = 1'b0;
  logic        rxd_endofpacket = 1'b0;
  logic        rxd_idle = 1'b1;
  logic        rd_pop = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        overrun;
  logic        rx_active;
  logic        irq;

  serial_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_div_we(cfg_div_we),
    .rx_en(rx_en), .cfg_thresh(cfg_thresh), .irq_mask(irq_mask), .ovr_clr(ovr_clr),
    .baud8tick(baud8tick), .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready),
    .rxd_endofpacket(rxd_endofpacket), .rxd_idle(rxd_idle), .rd_pop(rd_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .overrun(overrun), .rx_active(rx_active), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit saw_tick;

  // reference model state
  int  m_mode, m_div, m_phase;
  byte unsigned m_q[$];
  bit  m_ovr, m_tmo, m_irq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_OFF; m_div = 26; m_phase = 0;
    m_q.delete(); m_ovr = 1'b0; m_tmo = 1'b0; m_irq = 1'b0;
  endfunction

  // One clock of the reference model, from the current inputs.
  function automatic void model_step();
    bit tick, acc, pop, push, thr, drop, to_off;
    int n, nxt;
    n    = m_q.size();
    tick = (m_mode != M_OFF) && (m_phase == 0);
    acc  = (m_mode == M_RUN) || (m_mode == M_STOP);
    pop  = rd_pop && (n > 0);
    push = rxd_data_ready && acc;
    drop = push && (n == DEPTH) && !pop;
    thr  = (cfg_thresh != 5'd0) && (n >= int'(cfg_thresh));
    nxt  = m_mode;
    if (m_mode == M_OFF && rx_en) nxt = M_ARM;
    else if (m_mode == M_ARM) nxt = !rx_en ? M_OFF : ((tick && rxd_idle) ? M_RUN : M_ARM);
    else if (m_mode == M_RUN && !rx_en) nxt = rxd_idle ? M_OFF : M_STOP;
    else if (m_mode == M_STOP) nxt = rxd_idle ? M_OFF : (rx_en ? M_RUN : M_STOP);
    to_off = (nxt == M_OFF) && (m_mode != M_OFF);
    m_irq = (irq_mask[2] && m_tmo) || (irq_mask[1] && thr) || (irq_mask[0] && m_ovr);
    if (to_off) m_tmo = 1'b0;
    else if (rxd_endofpacket && acc && n != 0) m_tmo = 1'b1;
    else if (pop) m_tmo = 1'b0;
    if (m_mode == M_OFF || m_phase == 0) m_phase = m_div;
    else m_phase = m_phase - 1;
    if (cfg_div_we) m_div = int'(cfg_div);
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(rxd_data);
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    m_mode = nxt;
  endfunction

  task automatic check_outputs();
    check_eq("baud8tick", baud8tick, (m_mode != M_OFF) && (m_phase == 0));
    check_eq("rd_valid", rd_valid, m_q.size() != 0);
    check_eq("fifo_count", fifo_count, m_q.size());
    if (m_q.size() != 0) check_eq("rd_data", rd_data, m_q[0]);
    check_eq("overrun", overrun, m_ovr);
    check_eq("rx_active", rx_active, m_mode == M_RUN);
    check_eq("irq", irq, m_irq);
  endtask

  // One clock: compare at negedge, step model, advance; clear pulse inputs.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    saw_tick = baud8tick;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    cfg_div_we = 1'b0; rxd_data_ready = 1'b0; rxd_endofpacket = 1'b0;
    rd_pop = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic wait_tick(output int at);
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (saw_tick) begin
        at = cyc;
        return;
      end
    end
    check_eq("tick_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (rx_active) return;
    end
    check_eq("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [7:0] b);
    rxd_data = b;
    rxd_data_ready = 1'b1;
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tick"}, baud8tick, 32'd0);
    check_eq({tag, "_valid"}, rd_valid, 32'd0);
    check_eq({tag, "_count"}, fifo_count, 32'd0);
    check_eq({tag, "_ovr"}, overrun, 32'd0);
    check_eq({tag, "_active"}, rx_active, 32'd0);
    check_eq({tag, "_irq"}, irq, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, ntick, pop_div;
    logic [7:0] exp3 [3];
    logic [7:0] ev;
    exp3[0] = 8'h55; exp3[1] = 8'hA3; exp3[2] = 8'h0F;

    // reset values
    #2;
    check_reset_outputs("reset");
    model_reset();
    #5 rst_n = 1'b1;

    // baud generation: ARM -> RUN, period 27, then divisor change
    rx_en = 1'b1; rxd_idle = 1'b1;
    wait_run();
    wait_tick(t0); wait_tick(t1);
    check_eq("period_27a", t1 - t0, 32'd27);
    wait_tick(t2);
    check_eq("period_27b", t2 - t1, 32'd27);
    for (int i = 0; i < 4; i++) cycle();
    cfg_div = 16'd3; cfg_div_we = 1'b1;
    cycle();
    wait_tick(t3);
    check_eq("old_period", t3 - t2, 32'd27);
    wait_tick(t4);
    check_eq("new_period_a", t4 - t3, 32'd4);
    wait_tick(t0);
    check_eq("new_period_b", t0 - t4, 32'd4);

    // receive three bytes and read them back in order
    for (int i = 0; i < 3; i++) push(exp3[i]);
    check_eq("rx3_count", fifo_count, 32'd3);
    check_eq("rx3_head", rd_data, 32'h55);
    for (int i = 0; i < 3; i++) begin
      check_eq("rx3_pop_data", rd_data, exp3[i]);
      rd_pop = 1'b1;
      cycle();
    end
    check_eq("rx3_empty_valid", rd_valid, 32'd0);
    check_eq("rx3_empty_count", fifo_count, 32'd0);
    rd_pop = 1'b1;  // pop on empty is ignored
    cycle();
    check_eq("pop_empty_count", fifo_count, 32'd0);

    // overflow: 17 pushes, 17th lost
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    check_eq("ovf_count", fifo_count, 32'd16);
    check_eq("ovf_flag", overrun, 32'd1);
    ovr_clr = 1'b1;
    cycle();
    check_eq("ovf_clr", overrun, 32'd0);
    rxd_data = 8'hEE; rxd_data_ready = 1'b1; rd_pop = 1'b1;
    cycle();
    check_eq("full_pushpop_count", fifo_count, 32'd16);
    check_eq("full_pushpop_ovr", overrun, 32'd0);
    for (int i = 0; i < 16; i++) begin
      ev = (i < 15) ? 8'h11 + 8'(i) : 8'hEE;
      check_eq("ovf_drain", rd_data, ev);
      rd_pop = 1'b1;
      cycle();
    end

    // disable mid-frame: STOP keeps ticking, accepts the byte, then OFF
    rxd_idle = 1'b0; rx_en = 1'b0;
    cycle();
    check_eq("stop_active", rx_active, 32'd0);
    wait_tick(t0);
    push(8'h7E);
    check_eq("stop_count", fifo_count, 32'd1);
    rxd_idle = 1'b1;
    cycle();
    ntick = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (saw_tick) ntick++;
    end
    check_eq("off_no_ticks", ntick, 32'd0);
    check_eq("off_retained", rd_data, 32'h7E);
    rd_pop = 1'b1;
    cycle();

    // interrupts: threshold then timeout keeps irq high
    irq_mask = 3'b110; cfg_thresh = 5'd2;
    rx_en = 1'b1; rxd_idle = 1'b1;
    wait_run();
    push(8'h01); push(8'h02);
    check_eq("irq_lag", irq, 32'd0);
    cycle();
    check_eq("irq_thresh", irq, 32'd1);
    rd_pop = 1'b1; rxd_endofpacket = 1'b1;
    cycle();
    check_eq("irq_pop1_count", fifo_count, 32'd1);
    cycle();
    check_eq("irq_timeout", irq, 32'd1);
    rd_pop = 1'b1;
    cycle();
    cycle();
    check_eq("irq_cleared", irq, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        irq_mask   = 3'($urandom);
        cfg_thresh = 5'($urandom_range(0, 16));
      end
      pop_div = ((i / 500) % 2 == 1) ? 6 : 2;
      if ($urandom_range(0, 49) == 0) rx_en = ~rx_en;
      rxd_idle        = ($urandom_range(0, 3) != 0);
      rxd_data        = 8'($urandom);
      rxd_data_ready  = ($urandom_range(0, 2) == 0);
      rd_pop          = ($urandom_range(0, pop_div) == 0);
      rxd_endofpacket = ($urandom_range(0, 15) == 0);
      ovr_clr         = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) begin
        cfg_div = 16'($urandom_range(0, 5));
        cfg_div_we = 1'b1;
      end
      cycle();
    end

    // reset mid-RUN with five bytes held
    rx_en = 1'b1; rxd_idle = 1'b1;
    wait_run();
    while (m_q.size() != 0) begin
      rd_pop = 1'b1;
      cycle();
    end
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    check_eq("prerst_count", fifo_count, 32'd5);
    check_eq("prerst_active", rx_active, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    rx_en = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
- Controller for the 8N1 asynchronous receiver datapath.
- Generates the receiver's 8x-oversample baud tick from a programmable divisor.
- Sequences enable/disable so the receiver only starts or stops on an idle line.
- Buffers received bytes in a first-word-fall-through FIFO; raises overrun, threshold and packet-gap interrupt conditions for the CPU-side serial port.

Parameters:
- DIV_W, 16, width of baud divisor; tick period = cfg_div+1 clocks.
- DIV_RST, 16'd26, divisor loaded at reset.
- AW, 4, FIFO address width; depth = 2**AW entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_div  in  DIV_W  new baud divisor value
- cfg_div_we  in  1  load cfg_div into divisor register
- rx_en  in  1  receive enable request (level)
- cfg_thresh  in  AW+1  FIFO fill threshold for irq_thresh
- irq_mask  in  3  enables for {timeout, thresh, overrun}
- ovr_clr  in  1  clear sticky overrun flag
- baud8tick  out  1  one-clock tick to receiver
- rxd_data  in  8  byte from receiver
- rxd_data_ready  in  1  byte valid pulse from receiver
- rxd_endofpacket  in  1  gap-detected pulse from receiver
- rxd_idle  in  1  receiver line idle
- rd_pop  in  1  consume FIFO head
- rd_data  out  8  FIFO head byte (valid when rd_valid)
- rd_valid  out  1  FIFO non-empty
- fifo_count  out  AW+1  entries held, 0..2**AW
- overrun  out  1  sticky: byte dropped on full FIFO
- rx_active  out  1  controller in RUN
- irq  out  1  OR of masked interrupt sources

Behaviour:
- Reset values: baud8tick=0, rd_valid=0, fifo_count=0, overrun=0, rx_active=0, irq=0, divisor=DIV_RST, baud counter=0, state=OFF, timeout flag=0, FIFO pointers=0.
- Baud generator: down-counter runs only in ARM, RUN, STOP; in OFF it is held at divisor and baud8tick=0.
  - Counter at 0 → baud8tick=1 for that cycle and reload from divisor; otherwise decrement.
  - Divisor 0 → tick every clock.
  - cfg_div_we updates the divisor register next cycle; the new value is used at the next reload (no mid-period truncation).
- FSM (registered, evaluated every clk):
  - OFF: rx_en=1 → ARM.
  - ARM: ticks running; waits for rxd_idle=1 sampled on a baud8tick → RUN. rx_en=0 → OFF.
  - RUN: rx_active=1; bytes accepted. rx_en=0 with rxd_idle=1 → OFF; rx_en=0 with rxd_idle=0 → STOP.
  - STOP: ticks continue so the in-flight frame completes; its byte is still accepted; rxd_idle=1 → OFF; rx_en=1 → RUN.
  - Illegal encoding → OFF.
- Push: rxd_data_ready=1 in RUN or STOP writes rxd_data at the tail. Pulses in OFF/ARM are ignored.
- Pop: rd_pop=1 with rd_valid=1 advances the head; rd_pop on empty is ignored. rd_data is a combinational read of the head entry.
- Full FIFO plus push without pop: byte dropped, overrun set next cycle, count unchanged.
- Full FIFO with simultaneous push and pop: both occur, count stays 2**AW, no overrun.
- Empty FIFO with simultaneous push and pop: pop ignored, push accepted, count becomes 1.
- Pointers wrap modulo 2**AW; count uses AW+1 bits to distinguish full from empty.
- overrun: sticky until ovr_clr; a set and clear in the same cycle leaves it set.
- Timeout flag: set on rxd_endofpacket while count≠0 in RUN/STOP; cleared on any accepted pop or on entry to OFF.
- irq_thresh source: fifo_count >= cfg_thresh, with cfg_thresh≠0.
- irq = registered (mask[2]&timeout | mask[1]&thresh | mask[0]&overrun); one-cycle latency.
- Entry to OFF does not flush the FIFO; buffered bytes remain readable.
- Reset mid-frame: all state cleared immediately; FIFO contents are lost.

Optional Feature:
- Macro SERIAL_RX_CTRL_STATS_EN.
- Defined: adds outputs stat_bytes[15:0] and stat_drops[15:0].
  - stat_bytes: saturating count of accepted pushes.
  - stat_drops: saturating count of overrun drops.
  - Both are reset by rst_n and cleared by a new input stat_clr (1 bit).
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Divisor/baud: reset, rx_en=1, line idle → ARM then RUN; baud8tick exactly every 27 clocks. Write cfg_div=3 mid-period → old period completes, then ticks every 4 clocks.
- Receive and read: 3 pushes 0x55, 0xA3, 0x0F in RUN → fifo_count=3, rd_data=0x55. Three pops → bytes appear in order, then rd_valid=0, count=0.
- Overflow: AW=4, 17 pushes without pop → count=16, overrun=1, 17th byte lost. Push+pop together when full → count 16, no new overrun. ovr_clr → overrun=0.
- Disable mid-frame: rx_en=0 while rxd_idle=0 → STOP; ticks continue; frame's byte accepted; rxd_idle=1 → OFF, ticks stop, FIFO retained.
- Interrupts: mask=3'b110, cfg_thresh=2; two pushes → irq=1 one cycle after count reaches 2. Pop to count 1, then rxd_endofpacket → irq stays 1 via timeout. Pop to 0 → irq=0.
- Reset: assert rst_n low mid-RUN with count=5 → all outputs take reset values asynchronously, with no baud8tick.
